fetch_unit: RTL

Program-counter and IF/ID stage that sits directly upstream of the 1 KiB byte-addressed instruction memory. It drives the memory address and captures the returned 32-bit little-endian word into an IF/ID register for decode. It handles sequential fetch, branch and jump redirects, stalls, flushes, and out-of-range or misaligned fetch faults.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_unit_if_id_reg.sv | 56 +++++
 rtl/fetch_unit.sv | 126 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch stage.
//   fetch_state_e : BOOT / RUN / FAULT sequencing of the fetch unit
//   NOP_INSTR     : encoding loaded into IF/ID for a bubble
//   INSTR_W       : instruction / address width
//   JIDX_W        : J-format instr_index field width
//   jump_target() : J-format absolute target from PC+4 and instr_index
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    localparam int                 INSTR_W   = 32;
    localparam int                 JIDX_W    = 26;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    // Top nibble comes from PC+4, the rest from the index, word aligned.
    function automatic logic [INSTR_W-1:0] jump_target(
        input logic [INSTR_W-1:0] pc4,
        input logic [JIDX_W-1:0]  idx
    );
        return {pc4[31:28], idx, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// if_id_reg: IF/ID pipeline register (instruction, PC+4, valid).
//   clk, rst_n      : clock, async active-low reset
//   hold_i          : keep current contents
//   bubble_i        : load a NOP bubble (wins over hold_i)
//   instr_i, pc4_i  : values loaded when neither hold nor bubble
//   instr_o, pc4_o, valid_o : registered outputs
module if_id_reg
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hold_i,
    input  logic               bubble_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [INSTR_W-1:0] pc4_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [INSTR_W-1:0] pc4_o,
    output logic               valid_o
);

    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [INSTR_W-1:0] pc4_q, pc4_d;
    logic               valid_q, valid_d;

    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (bubble_i) begin
            instr_d = NOP_INSTR;
            pc4_d   = '0;
            valid_d = 1'b0;
        end else if (!hold_i) begin
            instr_d = instr_i;
            pc4_d   = pc4_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= NOP_INSTR;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, next-PC selection and IF/ID stage in front of a
// combinational byte-addressed instruction memory.
//   clk, rst_n                      : clock, async active-low reset
//   stall_i, flush_i                : hold PC+IF/ID / squash IF/ID
//   branch_taken_i, branch_target_i : redirect to full byte address
//   jump_i, jump_index_i            : redirect to J-format target
//   imem_addr_o, imem_data_i        : memory address (= PC) / returned word
//   if_id_instr_o, if_id_pc4_o, if_id_valid_o : IF/ID contents
//   fault_o                         : sticky misaligned/out-of-range fetch fault
// Optional: define FETCH_PERF_CNT_EN to add saturating counters
//   perf_fetch_o (valid IF/ID loads) and perf_bubble_o (bubbles loaded in RUN).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               branch_taken_i,
    input  logic [INSTR_W-1:0] branch_target_i,
    input  logic               jump_i,
    input  logic [JIDX_W-1:0]  jump_index_i,
    output logic [INSTR_W-1:0] imem_addr_o,
    input  logic [INSTR_W-1:0] imem_data_i,
    output logic [INSTR_W-1:0] if_id_instr_o,
    output logic [INSTR_W-1:0] if_id_pc4_o,
    output logic               if_id_valid_o,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]        perf_fetch_o,
    output logic [31:0]        perf_bubble_o,
`endif
    output logic               fault_o
);

    localparam logic [INSTR_W-1:0] LAST_PC = INSTR_W'(IMEM_BYTES - 4);

    fetch_state_e       state_q, state_d;
    logic [INSTR_W-1:0] pc_q, pc_d, pc4, next_pc;
    logic               bad_next, ifid_hold, ifid_bubble;

    always_comb begin
        pc4 = pc_q + 32'd4;

        if (branch_taken_i)    next_pc = branch_target_i;
        else if (jump_i)       next_pc = jump_target(pc4, jump_index_i);
        else if (stall_i)      next_pc = pc_q;
        else                   next_pc = pc4;

        bad_next = (next_pc[1:0] != 2'b00) || (next_pc > LAST_PC);

        // BOOT and FAULT keep IF/ID as is: it already holds a bubble there.
        state_d     = state_q;
        pc_d        = pc_q;
        ifid_hold   = 1'b1;
        ifid_bubble = 1'b0;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (bad_next) begin
                    // Faulting fetch: PC keeps the last good address.
                    state_d     = FAULT;
                    ifid_bubble = 1'b1;
                end else begin
                    pc_d        = next_pc;
                    // Redirects squash the wrong-path fetch even while stalled.
                    ifid_bubble = branch_taken_i | jump_i | flush_i;
                    ifid_hold   = stall_i;
                end
            end
            FAULT:   state_d = FAULT;
            default: state_d = FAULT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    if_id_reg u_if_id (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold_i   (ifid_hold),
        .bubble_i (ifid_bubble),
        .instr_i  (imem_data_i),
        .pc4_i    (pc4),
        .instr_o  (if_id_instr_o),
        .pc4_o    (if_id_pc4_o),
        .valid_o  (if_id_valid_o)
    );

    assign imem_addr_o = pc_q;
    assign fault_o     = (state_q == FAULT);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_bubble_q;
    logic        fetch_ev, bubble_ev;

    assign fetch_ev  = (state_q == RUN) && !ifid_bubble && !ifid_hold;
    assign bubble_ev = (state_q == RUN) && ifid_bubble;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_q  <= '0;
            perf_bubble_q <= '0;
        end else begin
            if (fetch_ev && perf_fetch_q != 32'hFFFF_FFFF)
                perf_fetch_q <= perf_fetch_q + 32'd1;
            if (bubble_ev && perf_bubble_q != 32'hFFFF_FFFF)
                perf_bubble_q <= perf_bubble_q + 32'd1;
        end
    end

    assign perf_fetch_o  = perf_fetch_q;
    assign perf_bubble_o = perf_bubble_q;
`endif

endmodule
